// File: rtl/reg_write_arbiter.sv
// Shares the register-file write port between the WB stage and a buffered long-latency requester.
// Optional macro REG_ARB_BYPASS_EN lets an ext result skip the FIFO when the port is otherwise idle.
module reg_write_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wb_en,
  input  logic [ADDR_WIDTH-1:0]            wb_addr,
  input  logic [DATA_WIDTH-1:0]            wb_data,
  output logic                             wb_stall,
  input  logic                             ext_valid,
  input  logic [ADDR_WIDTH-1:0]            ext_addr,
  input  logic [DATA_WIDTH-1:0]            ext_data,
  output logic                             ext_ready,
  input  logic [ADDR_WIDTH-1:0]            chk_addr_1,
  input  logic [ADDR_WIDTH-1:0]            chk_addr_2,
  output logic                             chk_hit_1,
  output logic                             chk_hit_2,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  pending_cnt,
  output logic                             write_en,
  output logic [ADDR_WIDTH-1:0]            write_addr,
  output logic [DATA_WIDTH-1:0]            write_data
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);

  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_WB   = 2'd1;
  localparam logic [1:0] GNT_FIFO = 2'd2;
  localparam logic [1:0] GNT_BYP  = 2'd3;

  logic [ADDR_WIDTH-1:0] mem_addr_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] mem_addr_d [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_data_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_data_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [STV_W-1:0]      starve_cnt_q, starve_cnt_d;
  logic                  write_en_q, write_en_d;
  logic [ADDR_WIDTH-1:0] write_addr_q, write_addr_d;
  logic [DATA_WIDTH-1:0] write_data_q, write_data_d;

  logic                  fifo_empty, fifo_full, starve_flag, ext_hs;
  logic                  push, pop;
  logic [1:0]            gnt_sel;
  logic [ADDR_WIDTH-1:0] gnt_addr;
  logic [DATA_WIDTH-1:0] gnt_data;
  logic                  fifo_hit_1, fifo_hit_2;

  assign fifo_empty  = (count_q == '0);
  assign fifo_full   = (count_q == DEPTH_CNT);
  assign ext_ready   = rst && !fifo_full;
  assign starve_flag = rst && !fifo_empty && (starve_cnt_q == STARVE_MAX);
  assign wb_stall    = starve_flag;
  assign ext_hs      = ext_valid && ext_ready;

  always_comb begin
    gnt_sel = GNT_NONE;
    if (!rst)
      gnt_sel = GNT_NONE;
    else if (starve_flag)
      gnt_sel = GNT_FIFO;
    else if (wb_en)
      gnt_sel = GNT_WB;
    else if (!fifo_empty)
      gnt_sel = GNT_FIFO;
`ifdef REG_ARB_BYPASS_EN
    else if (ext_hs)
      gnt_sel = GNT_BYP;
`endif
  end

  always_comb begin
    gnt_addr = '0;
    gnt_data = '0;
    case (gnt_sel)
      GNT_WB: begin
        gnt_addr = wb_addr;
        gnt_data = wb_data;
      end
      GNT_FIFO: begin
        gnt_addr = mem_addr_q[rd_ptr_q];
        gnt_data = mem_data_q[rd_ptr_q];
      end
      GNT_BYP: begin
        gnt_addr = ext_addr;
        gnt_data = ext_data;
      end
      default: begin
        gnt_addr = '0;
        gnt_data = '0;
      end
    endcase
  end

  // A bypassed handshake is consumed directly and never occupies a slot.
  assign push = ext_hs && (gnt_sel != GNT_BYP);
  assign pop  = (gnt_sel == GNT_FIFO);

  always_comb begin
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) begin
      mem_addr_d[wr_ptr_q] = ext_addr;
      mem_data_d[wr_ptr_q] = ext_data;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (pop)
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)
      count_d = count_q + CNT_W'(1);
    else if (pop && !push)
      count_d = count_q - CNT_W'(1);
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (fifo_empty || pop)
      starve_cnt_d = '0;
    else if (starve_cnt_q != STARVE_MAX)
      starve_cnt_d = starve_cnt_q + STV_W'(1);
  end

  always_comb begin
    write_en_d   = (gnt_sel != GNT_NONE) && (gnt_addr != '0);
    write_addr_d = gnt_addr;
    write_data_d = gnt_data;
  end

  // Only slots between the read pointer and read pointer + count hold live entries.
  always_comb begin
    logic [PTR_W-1:0] offset;
    fifo_hit_1 = 1'b0;
    fifo_hit_2 = 1'b0;
    offset     = '0;
    for (int j = 0; j < FIFO_DEPTH; j++) begin
      offset = PTR_W'(j) - rd_ptr_q;
      if (CNT_W'(offset) < count_q) begin
        if (mem_addr_q[j] == chk_addr_1) fifo_hit_1 = 1'b1;
        if (mem_addr_q[j] == chk_addr_2) fifo_hit_2 = 1'b1;
      end
    end
  end

  assign chk_hit_1 = rst && (chk_addr_1 != '0) &&
                     (fifo_hit_1 || (write_en_q && (write_addr_q == chk_addr_1)));
  assign chk_hit_2 = rst && (chk_addr_2 != '0) &&
                     (fifo_hit_2 || (write_en_q && (write_addr_q == chk_addr_2)));

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      starve_cnt_q <= '0;
      write_en_q   <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      starve_cnt_q <= starve_cnt_d;
      write_en_q   <= write_en_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_addr_q <= mem_addr_d;
    mem_data_q <= mem_data_d;
  end

  assign pending_cnt = count_q;
  assign write_en    = write_en_q;
  assign write_addr  = write_addr_q;
  assign write_data  = write_data_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Randomized bench for reg_write_arbiter: a queue-based reference model predicts every
// register-file write, which a separate monitor checks one cycle after it is issued.
module tb_reg_write_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_en;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          wb_stall;
  logic          ext_valid;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_data;
  logic          ext_ready;
  logic [AW-1:0] chk_addr_1, chk_addr_2;
  logic          chk_hit_1, chk_hit_2;
  logic [1:0]    pending_cnt;
  logic          write_en;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] write_data;

  reg_write_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wb_stall(wb_stall),
    .ext_valid(ext_valid), .ext_addr(ext_addr), .ext_data(ext_data), .ext_ready(ext_ready),
    .chk_addr_1(chk_addr_1), .chk_addr_2(chk_addr_2),
    .chk_hit_1(chk_hit_1), .chk_hit_2(chk_hit_2),
    .pending_cnt(pending_cnt),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  typedef struct {
    logic          en;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  entry_t model_fifo[$];
  wr_t    exp_q[$];
  int     model_starve = 0;
  logic   last_en = 1'b0;
  logic [AW-1:0] last_addr = '0;
  int     tests = 0;
  int     fails = 0;

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_hit(input logic [AW-1:0] a);
    logic h;
    h = 1'b0;
    if (a != 0) begin
      foreach (model_fifo[i]) if (model_fifo[i].addr == a) h = 1'b1;
      if (last_en && last_addr == a) h = 1'b1;
    end
    return h;
  endfunction

  // One cycle: drive inputs, check combinational outputs, advance model, queue the expected write.
  task automatic applyStimulus(input logic r, input logic we, input logic [AW-1:0] wa,
                               input logic [DW-1:0] wd, input logic ev, input logic [AW-1:0] ea,
                               input logic [DW-1:0] ed, input logic [AW-1:0] c1,
                               input logic [AW-1:0] c2);
    logic   empty, full, starve, granted, from_fifo;
    entry_t g;
    wr_t    w;
    @(negedge clk);
    rst = r; wb_en = we; wb_addr = wa; wb_data = wd;
    ext_valid = ev; ext_addr = ea; ext_data = ed;
    chk_addr_1 = c1; chk_addr_2 = c2;
    #1;
    empty = (model_fifo.size() == 0);
    full  = (model_fifo.size() == DEPTH);
    checkOutput("pending_cnt", DW'(pending_cnt), DW'(model_fifo.size()));
    if (!r) begin
      checkOutput("ext_ready_rst", DW'(ext_ready), 0);
      checkOutput("wb_stall_rst", DW'(wb_stall), 0);
      checkOutput("chk_hit_1_rst", DW'(chk_hit_1), 0);
      checkOutput("chk_hit_2_rst", DW'(chk_hit_2), 0);
      model_fifo.delete();
      model_starve = 0;
      last_en = 1'b0;
      last_addr = '0;
      w.en = 1'b0; w.addr = '0; w.data = '0;
      exp_q.push_back(w);
      return;
    end
    starve = (model_starve == LIMIT) && !empty;
    checkOutput("ext_ready", DW'(ext_ready), DW'(!full));
    checkOutput("wb_stall", DW'(wb_stall), DW'(starve));
    checkOutput("chk_hit_1", DW'(chk_hit_1), DW'(model_hit(c1)));
    checkOutput("chk_hit_2", DW'(chk_hit_2), DW'(model_hit(c2)));
    granted = 1'b0; from_fifo = 1'b0;
    g.addr = '0; g.data = '0;
    if (starve || (!we && !empty)) begin
      g = model_fifo.pop_front();
      granted = 1'b1; from_fifo = 1'b1;
    end else if (we) begin
      g.addr = wa; g.data = wd; granted = 1'b1;
    end
`ifdef REG_ARB_BYPASS_EN
    else if (ev && empty) begin
      g.addr = ea; g.data = ed; granted = 1'b1;
      ev = 1'b0;
    end
`endif
    if (ev && !full) begin
      entry_t e;
      e.addr = ea; e.data = ed;
      model_fifo.push_back(e);
    end
    if (empty || from_fifo) model_starve = 0;
    else if (model_starve < LIMIT) model_starve++;
    w.en   = granted && (g.addr != 0);
    w.addr = g.addr;
    w.data = g.data;
    exp_q.push_back(w);
    last_en   = w.en;
    last_addr = w.addr;
  endtask

  // Monitor: the registered write port is compared every cycle against the oldest prediction.
  initial begin
    wr_t w;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        checkOutput("write_en", DW'(write_en), DW'(w.en));
        checkOutput("write_addr", DW'(write_addr), DW'(w.addr));
        checkOutput("write_data", write_data, w.data);
      end
    end
  end

  initial begin
    rst = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    ext_valid = 1'b0; ext_addr = '0; ext_data = '0;
    chk_addr_1 = '0; chk_addr_2 = '0;

    // Reset with requests asserted.
    applyStimulus(0, 1, 5'd4, 32'h1, 1, 5'd6, 32'h2, 5'd6, 5'd4);
    applyStimulus(0, 1, 5'd4, 32'h1, 1, 5'd6, 32'h2, 5'd6, 5'd4);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 5'd6, 5'd4);

    // WB only.
    applyStimulus(1, 1, 5'd5, 32'h00001234, 0, 0, 0, 5'd5, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 5'd5, 0);

    // Idle ext push.
    applyStimulus(1, 0, 0, 0, 1, 5'd3, 32'hA, 5'd3, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 5'd3, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 5'd3, 0);

    // Starvation: continuous WB while one ext entry waits.
    applyStimulus(1, 1, 5'd1, 32'h100, 1, 5'd7, 32'h55, 5'd7, 0);
    for (int i = 0; i < 8; i++)
      applyStimulus(1, 1, 5'(i + 1), 32'h200 + i, 0, 0, 0, 5'd7, 5'(i + 1));

    // Full FIFO and address hits.
    applyStimulus(1, 1, 5'd2, 32'h300, 1, 5'd9, 32'h9, 0, 0);
    applyStimulus(1, 1, 5'd2, 32'h301, 1, 5'd10, 32'h10, 5'd9, 0);
    applyStimulus(1, 1, 5'd2, 32'h302, 1, 5'd11, 32'h11, 5'd9, 0);
    applyStimulus(1, 1, 5'd2, 32'h303, 1, 5'd11, 32'h11, 5'd10, 5'd11);
    for (int i = 0; i < 10; i++)
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 5'd11, 5'd10);

    // Zero address from WB and from ext.
    applyStimulus(1, 1, 5'd0, 32'hDEAD, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 5'd0, 32'hBEEF, 1, 5'd0, 32'hCAFE, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic with occasional mid-stream reset.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 63) != 0),
                    ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 9)), $urandom(),
                    ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 9)), $urandom(),
                    5'($urandom_range(0, 9)), 5'($urandom_range(0, 9)));
    end

    @(posedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
Shares the single register-file write port between the in-order pipeline write-back stage and one long-latency requester (mult/div unit, cache-miss load return). The long-latency requester uses a valid/ready handshake. Its results are buffered in a small FIFO and written into idle WB slots, and WB is stalled only when a buffered result has starved for too long. The block also reports which register addresses still have buffered writes pending, so decode can stall on them.

Parameters:
DATA_WIDTH, 32, register data width
ADDR_WIDTH, 5, register address width
FIFO_DEPTH, 2, buffered ext entries; power of 2, >=2
STARVE_LIMIT, 4, cycles a non-empty FIFO may go ungranted before WB is stalled; >=1

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous reset, active-low
wb_en  in  1  WB stage write request
wb_addr  in  ADDR_WIDTH  WB destination register
wb_data  in  DATA_WIDTH  WB write data
wb_stall  out  1  WB stage must hold; wb_* ignored this cycle
ext_valid  in  1  long-latency result valid
ext_addr  in  ADDR_WIDTH  ext destination register
ext_data  in  DATA_WIDTH  ext write data
ext_ready  out  1  FIFO can accept this cycle
chk_addr_1  in  ADDR_WIDTH  decode source address #1
chk_addr_2  in  ADDR_WIDTH  decode source address #2
chk_hit_1  out  1  chk_addr_1 has a pending write
chk_hit_2  out  1  chk_addr_2 has a pending write
pending_cnt  out  $clog2(FIFO_DEPTH+1)  valid FIFO entries
write_en  out  1  to register file write enable (registered)
write_addr  out  ADDR_WIDTH  to register file write address (registered)
write_data  out  DATA_WIDTH  to register file write data (registered)

Behaviour:
- Reset (rst==0 at posedge):
  - Clears FIFO pointers, pending_cnt, starve_cnt, and write_en/write_addr/write_data to 0.
  - While rst==0: ext_ready=0, wb_stall=0, chk_hit_*=0.
  - Reset mid-operation discards all buffered entries; no write is issued for them.
- Handshake: ext accepted when ext_valid && ext_ready.
  - ext_ready = !full. It does not depend on a same-cycle pop.
  - Accepted entry is pushed at the posedge and is visible at the FIFO head the next cycle.
- starve_flag = (starve_cnt == STARVE_LIMIT) && FIFO non-empty.
- Grant, combinational, one winner per cycle:
  1. starve_flag: EXT granted, wb_stall=1.
  2. else if wb_en: WB granted.
  3. else if FIFO non-empty: EXT granted.
  4. else: no grant.
- wb_stall = starve_flag; it is never asserted otherwise.
- An EXT grant pops the FIFO head at the posedge.
- starve_cnt:
  - Cleared when the FIFO is empty or EXT is granted.
  - Otherwise increments, saturating at STARVE_LIMIT.
- Output register, updated every posedge:
  - write_en <= granted && granted addr != 0.
  - write_addr/write_data <= granted addr/data.
  - On no grant, addr/data are set to 0.
  - Address 0 grants still consume the slot (and pop if EXT) but never assert write_en.
- Latency (default build):
  - WB request in cycle N appears on write_* in cycle N+1.
  - ext accept in cycle N appears in N+2 at the earliest.
- chk_hit_k = chk_addr_k != 0 and it matches any valid FIFO entry or (write_en && write_addr). Purely combinational.
- Ordering rule: the pipeline never issues a WB write to an address with chk_hit set. Decode stalls on chk_hit, and the arbiter does not reorder.
- Full: a third push with FIFO_DEPTH=2 is refused (ext_ready=0) until a pop completes.
- Pointers wrap modulo FIFO_DEPTH. pending_cnt is exact at every cycle, including simultaneous push+pop (unchanged).

Optional Feature:
REG_ARB_BYPASS_EN
- Defined: when the FIFO is empty, wb_en==0 and an ext handshake occurs, the ext request is granted directly in that cycle without a push. Write appears in N+1; starve_cnt is unaffected.
- Undefined: all ext requests go through the FIFO, minimum latency 2.

Test Plan:
1. Reset: rst=0 for 2 cycles with ext_valid=1 and wb_en=1 -> ext_ready=0, write_en=0, pending_cnt=0, nothing buffered after release.
2. WB only: wb_en=1, wb_addr=5, wb_data=0x00001234 in cycle N -> write_en=1, write_addr=5, write_data=0x00001234 in N+1; wb_stall=0 throughout.
3. Idle ext: wb_en=0, push addr=3 data=0xA in N -> write_en=1, addr 3, data 0xA in N+2 (N+1 with REG_ARB_BYPASS_EN); pending_cnt=1 in N+1 (0 with bypass).
4. Starvation: STARVE_LIMIT=4, wb_en=1 every cycle, push addr=7 data=0x55 in N -> wb_stall=1 only in N+5, write addr 7 in N+6, WB writes resume N+7.
5. Full/hit: FIFO_DEPTH=2, wb_en=1, pushes to addr 9 and 10 -> pending_cnt=2, ext_ready=0, chk_addr_1=9 gives chk_hit_1=1, chk_addr_2=0 gives chk_hit_2=0.
6. Zero address: wb_en with addr 0, then ext push with addr 0 -> write_en stays 0; ext entry pops (pending_cnt 1 to 0) with no write.
